// File: rtl/z80_prefetch.sv
// Z80 bus interface and instruction prefetch unit. It owns the single memory port,
// keeps a DEPTH-byte opcode queue ahead of the decoder and slots in one-byte data accesses.
module z80_prefetch #(
  parameter int            DEPTH    = 4,
  parameter int            LAT      = 1,
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          HOLD,
  output logic [AW-1:0] A,
  input  logic [7:0]    DI,
  output logic [7:0]    DO,
  output logic          W,
  output logic          q_valid,
  output logic [7:0]    q_data,
  output logic [AW-1:0] q_pc,
  input  logic          q_pop,
  input  logic          jmp,
  input  logic [AW-1:0] jmp_addr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [7:0]    d_wdata,
  output logic          d_ack,
  output logic [7:0]    d_rdata
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = 6;

  logic [AW-1:0]    fptr_reg, fptr_next;
  logic [7:0]       do_reg;
  logic             busy_reg, busy_next;
  logic             d_ack_reg, d_ack_next;
  logic [7:0]       d_rdata_reg;

  logic [LAT-1:0]   tag_vld_reg, tag_vld_next;
  logic [LAT-1:0]   tag_fetch_reg, tag_fetch_next;
  logic [AW-1:0]    tag_addr_reg  [LAT];
  logic [AW-1:0]    tag_addr_next [LAT];

  logic [DEPTH-1:0] q_vld_reg;
  logic             q_vld_next  [DEPTH];
  logic [7:0]       q_data_reg  [DEPTH];
  logic [7:0]       q_data_next [DEPTH];
  logic [AW-1:0]    q_pc_reg    [DEPTH];
  logic [AW-1:0]    q_pc_next   [DEPTH];
  logic [CW-1:0]    count_reg, count_next, wpos;

  logic             run, room, data_issue, fetch_issue;
  logic [2:0]       inflight;
  logic             ret_fetch, ret_data, push, pop_eff;

  always_comb begin
    inflight = '0;
    for (int k = 0; k < LAT; k++)
      inflight = inflight + 3'(tag_vld_reg[k] & tag_fetch_reg[k]);
  end

  // Credit counts bytes already queued plus fetches still on the bus, so a
  // return always finds a free slot even when nothing is popped.
  assign run         = HOLD & ~RESET;
  assign room        = (SW'(count_reg) + SW'(inflight)) < SW'(DEPTH);
  assign data_issue  = run & d_req & ~busy_reg;
  assign fetch_issue = run & ~data_issue & ~jmp & room;

  assign A  = data_issue ? d_addr : fptr_reg;
  assign W  = data_issue & d_we;
  assign DO = W ? d_wdata : do_reg;

  assign ret_fetch = tag_vld_reg[LAT-1] & tag_fetch_reg[LAT-1];
  assign ret_data  = tag_vld_reg[LAT-1] & ~tag_fetch_reg[LAT-1];
  assign push      = ret_fetch & ~jmp;
  assign pop_eff   = q_pop & q_vld_reg[0] & ~jmp;
  assign wpos      = count_reg - CW'(pop_eff);

  always_comb begin
    tag_vld_next      = tag_vld_reg << 1;
    tag_fetch_next    = tag_fetch_reg << 1;
    tag_vld_next[0]   = fetch_issue | (data_issue & ~d_we);
    tag_fetch_next[0] = fetch_issue;
    tag_addr_next[0]  = fptr_reg;
    for (int k = 1; k < LAT; k++)
      tag_addr_next[k] = tag_addr_reg[k-1];
    // A jump kills every fetch on the bus but lets a pending data read finish.
    if (jmp)
      tag_vld_next = tag_vld_next & ~tag_fetch_next;
  end

  always_comb begin
    fptr_next = fptr_reg;
    if (jmp)
      fptr_next = jmp_addr;
    else if (fetch_issue)
      fptr_next = fptr_reg + 1'b1;

    busy_next = busy_reg;
    if (data_issue)
      busy_next = 1'b1;
    else if (d_ack_reg)
      busy_next = 1'b0;

    d_ack_next = (data_issue & d_we) | ret_data;

    count_next = count_reg + CW'(push) - CW'(pop_eff);
    if (jmp)
      count_next = '0;
  end

  // Shift-down queue: entry 0 is always the head, so the head outputs come
  // straight from flops.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_q
      logic          shift_vld;
      logic [7:0]    shift_data;
      logic [AW-1:0] shift_pc;
      logic          take;
      if (gi < DEPTH - 1) begin : g_mid
        assign shift_vld  = pop_eff ? q_vld_reg[gi+1]  : q_vld_reg[gi];
        assign shift_data = pop_eff ? q_data_reg[gi+1] : q_data_reg[gi];
        assign shift_pc   = pop_eff ? q_pc_reg[gi+1]   : q_pc_reg[gi];
      end else begin : g_last
        assign shift_vld  = pop_eff ? 1'b0 : q_vld_reg[gi];
        assign shift_data = q_data_reg[gi];
        assign shift_pc   = q_pc_reg[gi];
      end
      assign take            = push & (wpos == CW'(gi));
      assign q_vld_next[gi]  = ~jmp & (take | shift_vld);
      assign q_data_next[gi] = take ? DI : shift_data;
      assign q_pc_next[gi]   = take ? tag_addr_reg[LAT-1] : shift_pc;
    end
  endgenerate

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      fptr_reg      <= RESET_PC;
      do_reg        <= '0;
      busy_reg      <= 1'b0;
      d_ack_reg     <= 1'b0;
      d_rdata_reg   <= '0;
      tag_vld_reg   <= '0;
      tag_fetch_reg <= '0;
      count_reg     <= '0;
      q_vld_reg     <= '0;
      for (int k = 0; k < LAT; k++)
        tag_addr_reg[k] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data_reg[i] <= '0;
        q_pc_reg[i]   <= RESET_PC;
      end
    end else begin
      fptr_reg      <= fptr_next;
      do_reg        <= DO;
      busy_reg      <= busy_next;
      d_ack_reg     <= d_ack_next;
      if (ret_data)
        d_rdata_reg <= DI;
      tag_vld_reg   <= tag_vld_next;
      tag_fetch_reg <= tag_fetch_next;
      count_reg     <= count_next;
      for (int k = 0; k < LAT; k++)
        tag_addr_reg[k] <= tag_addr_next[k];
      for (int i = 0; i < DEPTH; i++) begin
        q_vld_reg[i]  <= q_vld_next[i];
        q_data_reg[i] <= q_data_next[i];
        q_pc_reg[i]   <= q_pc_next[i];
      end
    end
  end

  assign q_valid = q_vld_reg[0];
  assign q_data  = q_data_reg[0];
  assign q_pc    = q_pc_reg[0];
  assign d_ack   = d_ack_reg;
  assign d_rdata = d_rdata_reg;

endmodule

// File: tb/tb_z80_prefetch.sv
// Bench for z80_prefetch: LAT-cycle synchronous memory with mem[i]=i, a head-of-stream
// model checked every cycle, and directed reset/backpressure/jump/data/wrap/HOLD scenarios.
module tb_z80_prefetch;
  localparam int          DEPTH    = 4;
  localparam int          LAT      = 2;
  localparam int          AW       = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        HOLD = 1'b1;
  logic [15:0] A;
  logic [7:0]  DI = 8'h00;
  logic [7:0]  DO;
  logic        W;
  logic        q_valid;
  logic [7:0]  q_data;
  logic [15:0] q_pc;
  logic        q_pop = 1'b0;
  logic        jmp = 1'b0;
  logic [15:0] jmp_addr = 16'h0000;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic [7:0]  d_wdata = 8'h00;
  logic        d_ack;
  logic [7:0]  d_rdata;
  logic        pop_en = 1'b1;

  int checks = 0;
  int errors = 0;

  z80_prefetch #(.DEPTH(DEPTH), .LAT(LAT), .AW(AW), .RESET_PC(RESET_PC)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .HOLD(HOLD), .A(A), .DI(DI), .DO(DO), .W(W),
    .q_valid(q_valid), .q_data(q_data), .q_pc(q_pc), .q_pop(q_pop),
    .jmp(jmp), .jmp_addr(jmp_addr), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata)
  );

  initial forever #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Synchronous memory: address of cycle t appears on DI during t+LAT.
  logic [7:0] mem  [0:65535];
  logic [7:0] pipe [LAT];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = i[7:0];
    for (int k = 0; k < LAT; k++) pipe[k] = 8'h00;
    forever begin
      @(posedge CLOCK);
      for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = mem[A];
      if (W === 1'b1) mem[A] = DO;
      DI <= pipe[LAT-1];
    end
  end

  // Core side: pop whenever the head is valid and popping is enabled.
  initial forever begin
    @(posedge CLOCK);
    #2;
    q_pop = pop_en & q_valid;
  end

  // Stream model: the head must walk consecutive addresses from the last
  // reset/jump target, carrying that address's memory byte.
  logic [15:0] exp_pc = 16'h0000;
  bit          exp_empty = 1'b0;
  initial forever begin
    @(posedge CLOCK);
    if (RESET) begin
      exp_pc = RESET_PC;
      exp_empty = 1'b1;
    end else if (jmp) begin
      exp_pc = jmp_addr;
      exp_empty = 1'b1;
    end else if (q_pop && q_valid) begin
      exp_pc = exp_pc + 16'd1;
    end
    @(negedge CLOCK);
    if (exp_empty) begin
      check("flush_empty", 32'(q_valid), 32'd0);
      exp_empty = 1'b0;
    end else if (q_valid === 1'b1) begin
      check("head_pc", 32'(q_pc), 32'(exp_pc));
      check("head_data", 32'(q_data), 32'(exp_pc[7:0]));
    end
    if (W === 1'b1) begin
      check("write_addr", 32'(A), 32'(d_addr));
      check("write_data", 32'(DO), 32'(d_wdata));
    end
  end

  task automatic find_valid(output int k);
    k = 1;
    forever begin
      @(negedge CLOCK);
      if (q_valid === 1'b1) break;
      if (k >= 20) begin
        k = -1;
        break;
      end
      step();
      k++;
    end
  endtask

  task automatic do_jump(input logic [15:0] addr);
    int k;
    step();
    jmp = 1'b1;
    jmp_addr = addr;
    step();
    jmp = 1'b0;
    find_valid(k);
    $display("jump to %h: first target byte after %0d cycles, pc=%h data=%h", addr, k, q_pc, q_data);
    check("jump_latency", 32'(k), 32'(LAT + 2));
    check("jump_first_pc", 32'(q_pc), 32'(addr));
    check("jump_first_data", 32'(q_data), 32'(addr[7:0]));
  endtask

  task automatic do_data(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                         output int lat, output logic [7:0] rdata);
    step();
    d_req = 1'b1;
    d_we = we;
    d_addr = addr;
    d_wdata = wdata;
    @(negedge CLOCK);
    check("data_issue_w", 32'(W), 32'(we));
    check("data_issue_a", 32'(A), 32'(addr));
    if (we) check("data_issue_do", 32'(DO), 32'(wdata));
    lat = 0;
    forever begin
      step();
      lat++;
      @(negedge CLOCK);
      if (d_ack === 1'b1) break;
      if (lat >= 20) begin
        lat = -1;
        break;
      end
    end
    check("ack_cycle_no_issue", 32'(W), 32'd0);
    rdata = d_rdata;
    step();
    d_req = 1'b0;
    $display("data %s addr=%h wdata=%h: ack after %0d cycles, rdata=%h",
             we ? "write" : "read", addr, wdata, lat, rdata);
  endtask

  initial begin
    int k;
    int n;
    int acks;
    int first;
    logic [15:0] hold_p;
    logic [7:0] rd;

    // Reset state
    repeat (3) step();
    @(negedge CLOCK);
    check("reset_q_valid", 32'(q_valid), 32'd0);
    check("reset_q_data", 32'(q_data), 32'd0);
    check("reset_q_pc", 32'(q_pc), 32'(RESET_PC));
    check("reset_A", 32'(A), 32'(RESET_PC));
    check("reset_W", 32'(W), 32'd0);
    check("reset_DO", 32'(DO), 32'd0);
    check("reset_d_ack", 32'(d_ack), 32'd0);
    check("reset_d_rdata", 32'(d_rdata), 32'd0);

    // First fetch and sustained stream
    step();
    RESET = 1'b0;
    find_valid(k);
    $display("reset release: first byte in cycle %0d pc=%h data=%h", k, q_pc, q_data);
    check("first_valid_cycle", 32'(k), 32'(LAT + 2));
    check("first_pc", 32'(q_pc), 32'h0000);
    check("first_data", 32'(q_data), 32'h00);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      @(negedge CLOCK);
      if (q_valid === 1'b1) n++;
    end
    check("sustained_rate", 32'(n), 32'd16);

    // Backpressure: fetching stops once DEPTH bytes are held
    step();
    pop_en = 1'b0;
    repeat (10) step();
    @(negedge CLOCK);
    check("full_q_valid", 32'(q_valid), 32'd1);
    check("full_fetch_ptr", 32'(A), 32'(exp_pc + 16'(DEPTH)));
    $display("backpressure: head pc=%h, fetch pointer=%h", q_pc, A);
    step();
    pop_en = 1'b1;
    repeat (8) step();

    // Jump with fetches in flight
    do_jump(16'h1234);
    repeat (6) step();

    // Data write then read back
    do_data(1'b1, 16'h8000, 8'hA5, k, rd);
    check("write_ack_latency", 32'(k), 32'd1);
    do_data(1'b0, 16'h8000, 8'h00, k, rd);
    check("read_ack_latency", 32'(k), 32'(LAT + 1));
    check("read_data", 32'(rd), 32'hA5);
    repeat (3) step();
    @(negedge CLOCK);
    check("rdata_held", 32'(d_rdata), 32'hA5);
    repeat (4) step();

    // Address wrap
    do_jump(16'hFFFE);
    step();
    @(negedge CLOCK);
    check("wrap_pc1", 32'(q_pc), 32'hFFFF);
    step();
    @(negedge CLOCK);
    check("wrap_pc2", 32'(q_pc), 32'h0000);
    repeat (6) step();

    // HOLD low for 5 cycles: in-flight bytes land, nothing new issues
    step();
    HOLD = 1'b0;
    n = 0;
    hold_p = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      @(negedge CLOCK);
      if (i == 0) hold_p = exp_pc;
      check("hold_W", 32'(W), 32'd0);
      check("hold_A", 32'(A), 32'(hold_p + 16'd3));
      if (q_valid === 1'b1) n++;
    end
    check("hold_drained_bytes", 32'(n), 32'd3);
    step();
    HOLD = 1'b1;
    find_valid(k);
    $display("hold released: stream resumes after %0d cycles at pc=%h", k, q_pc);
    check("hold_resume_latency", 32'(k), 32'(LAT + 2));
    repeat (4) step();

    // Reset one cycle after a data read issues
    step();
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 16'h4321;
    step();
    RESET = 1'b1;
    d_req = 1'b0;
    step();
    RESET = 1'b0;
    @(negedge CLOCK);
    check("midreset_q_valid", 32'(q_valid), 32'd0);
    check("midreset_A", 32'(A), 32'(RESET_PC));
    check("midreset_W", 32'(W), 32'd0);
    check("midreset_d_rdata", 32'(d_rdata), 32'd0);
    acks = (d_ack === 1'b1) ? 1 : 0;
    first = (q_valid === 1'b1) ? 1 : 0;
    for (int i = 2; i <= 12; i++) begin
      step();
      @(negedge CLOCK);
      if (d_ack === 1'b1) acks++;
      if (q_valid === 1'b1 && first == 0) first = i;
    end
    $display("reset mid-read: %0d acks, refetch valid in cycle %0d", acks, first);
    check("midreset_no_ack", 32'(acks), 32'd0);
    check("midreset_refetch", 32'(first), 32'(LAT + 2));
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
